simt_reconv_stack: RTL and testbench

// - Multi-warp SIMT divergence/reconvergence unit with an independent immediate-post-dominator stack per warp.
// - Sits between the warp scheduler/decoder and the fetch unit; one registered response per accepted request.
// - On a reconvergence pop, a warp gets back its own pre-branch mask, not the full warp.
// - Flags stack overflow and provides per-warp init and valid/ready backpressure.

---
 rtl/simt_reconv_stack.sv | 216 +++++++++++++++++++++
 tb/tb_simt_reconv_stack.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simt_reconv_stack.sv
// simt_reconv_stack: per-warp immediate-post-dominator stack for SIMT
// divergence and reconvergence. One registered response per accepted request;
// a reconvergence pop restores the warp's own pre-branch mask.
module simt_reconv_stack #(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 8,
    parameter int STACK_DEPTH      = 8,
    parameter int PC_BITS          = 8,
    parameter int WARP_BITS        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init_valid,
    input  logic [WARP_BITS-1:0]        init_warp,
    input  logic [THREADS_PER_WARP-1:0] init_mask,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [WARP_BITS-1:0]        req_warp,
    input  logic                        req_op,
    input  logic [THREADS_PER_WARP-1:0] branch_taken,
    input  logic [PC_BITS-1:0]          branch_target,
    input  logic [PC_BITS-1:0]          fallthrough_pc,
    input  logic [PC_BITS-1:0]          reconverge_pc,
    input  logic [PC_BITS-1:0]          current_pc,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [WARP_BITS-1:0]        resp_warp,
    output logic [THREADS_PER_WARP-1:0] resp_mask,
    output logic [PC_BITS-1:0]          resp_pc,
    output logic                        resp_diverged,
    output logic                        resp_error,
    output logic [NUM_WARPS-1:0]        overflow_sticky
);

    localparam int TPW = THREADS_PER_WARP;
    localparam int DW  = $clog2(STACK_DEPTH + 1);
    localparam int SW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Per-warp active mask, nesting depth and stack entry fields
    logic [TPW-1:0]     mask_q  [NUM_WARPS];
    logic [TPW-1:0]     mask_d  [NUM_WARPS];
    logic [DW-1:0]      depth_q [NUM_WARPS];
    logic [DW-1:0]      depth_d [NUM_WARPS];
    logic [PC_BITS-1:0] rpc_q   [NUM_WARPS][STACK_DEPTH];
    logic [PC_BITS-1:0] rpc_d   [NUM_WARPS][STACK_DEPTH];
    logic [PC_BITS-1:0] ppc_q   [NUM_WARPS][STACK_DEPTH];
    logic [PC_BITS-1:0] ppc_d   [NUM_WARPS][STACK_DEPTH];
    logic [TPW-1:0]     pm_q    [NUM_WARPS][STACK_DEPTH];
    logic [TPW-1:0]     pm_d    [NUM_WARPS][STACK_DEPTH];
    logic [TPW-1:0]     sm_q    [NUM_WARPS][STACK_DEPTH];
    logic [TPW-1:0]     sm_d    [NUM_WARPS][STACK_DEPTH];
    logic [NUM_WARPS-1:0] ovf_q, ovf_d;

    // Response registers
    logic                 resp_valid_q, resp_valid_d;
    logic [WARP_BITS-1:0] resp_warp_q, resp_warp_d;
    logic [TPW-1:0]       resp_mask_q, resp_mask_d;
    logic [PC_BITS-1:0]   resp_pc_q, resp_pc_d;
    logic                 resp_div_q, resp_div_d;
    logic                 resp_err_q, resp_err_d;

    // Decoded view of the addressed warp
    logic                 req_ready_s, accept_s, warp_ok_s, init_ok_s;
    logic [TPW-1:0]       cur_mask_s, taken_s, ntaken_s;
    logic [DW-1:0]        cur_depth_s;
    logic [SW-1:0]        tos_s, push_s;

    assign req_ready_s = !init_valid && (!resp_valid_q || resp_ready);
    assign accept_s    = req_valid && req_ready_s;
    assign warp_ok_s   = (32'(req_warp) < NUM_WARPS);
    assign init_ok_s   = (32'(init_warp) < NUM_WARPS);
    assign cur_mask_s  = mask_q[req_warp];
    assign cur_depth_s = depth_q[req_warp];
    assign tos_s       = SW'(cur_depth_s - DW'(1'b1));
    assign push_s      = SW'(cur_depth_s);
    assign taken_s     = cur_mask_s & branch_taken;
    assign ntaken_s    = cur_mask_s & ~branch_taken;

    // Next-state for warp stacks and response registers
    always_comb begin
        mask_d       = mask_q;
        depth_d      = depth_q;
        rpc_d        = rpc_q;
        ppc_d        = ppc_q;
        pm_d         = pm_q;
        sm_d         = sm_q;
        ovf_d        = ovf_q;
        resp_warp_d  = resp_warp_q;
        resp_mask_d  = resp_mask_q;
        resp_pc_d    = resp_pc_q;
        resp_div_d   = resp_div_q;
        resp_err_d   = resp_err_q;

        if (accept_s) begin
            resp_valid_d = 1'b1;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end

        if (init_valid) begin
            // Init wins the cycle; the request waits (req_ready is low)
            if (init_ok_s) begin
                mask_d[init_warp]  = init_mask;
                depth_d[init_warp] = {DW{1'b0}};
                ovf_d[init_warp]   = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end
        end else if (accept_s) begin
            resp_warp_d = req_warp;
            resp_err_d  = 1'b0;
            resp_pc_d   = current_pc;
            if (!warp_ok_s) begin
                resp_err_d  = 1'b1;
                resp_mask_d = {TPW{1'b0}};
                resp_div_d  = 1'b0;
            end else begin
                resp_mask_d = cur_mask_s;
                resp_div_d  = (cur_depth_s != {DW{1'b0}});
                case (req_op)
                    1'b1: begin
                        if (taken_s == cur_mask_s) begin
                            resp_pc_d = branch_target;
                        end else if (taken_s == {TPW{1'b0}}) begin
                            resp_pc_d = fallthrough_pc;
                        end else if (cur_depth_s < DW'(STACK_DEPTH)) begin
                            // Real divergence: run taken lanes, park the rest
                            rpc_d[req_warp][push_s] = reconverge_pc;
                            ppc_d[req_warp][push_s] = fallthrough_pc;
                            pm_d[req_warp][push_s]  = ntaken_s;
                            sm_d[req_warp][push_s]  = cur_mask_s;
                            mask_d[req_warp]        = taken_s;
                            depth_d[req_warp]       = cur_depth_s + DW'(1'b1);
                            resp_mask_d             = taken_s;
                            resp_pc_d               = branch_target;
                            resp_div_d              = 1'b1;
                        end else begin
                            // Stack full: leave state alone, flag the warp
                            resp_err_d      = 1'b1;
                            ovf_d[req_warp] = 1'b1;
                        end
                    end
                    default: begin
                        if ((cur_depth_s == {DW{1'b0}}) ||
                            (current_pc != rpc_q[req_warp][tos_s])) begin
                            resp_pc_d = current_pc;
                        end else if (pm_q[req_warp][tos_s] != {TPW{1'b0}}) begin
                            // Reached post-dominator with else-path pending
                            mask_d[req_warp]      = pm_q[req_warp][tos_s];
                            pm_d[req_warp][tos_s] = {TPW{1'b0}};
                            resp_mask_d           = pm_q[req_warp][tos_s];
                            resp_pc_d             = ppc_q[req_warp][tos_s];
                        end else begin
                            // Both paths done: restore pre-branch mask, pop
                            mask_d[req_warp]  = sm_q[req_warp][tos_s];
                            depth_d[req_warp] = cur_depth_s - DW'(1'b1);
                            resp_mask_d       = sm_q[req_warp][tos_s];
                            resp_div_d        = (cur_depth_s != DW'(1'b1));
                        end
                    end
                endcase
            end
        end else begin
            resp_err_d = resp_err_q;
        end
    end

    // State and response registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                mask_q[w]  <= {TPW{1'b1}};
                depth_q[w] <= {DW{1'b0}};
                for (int s = 0; s < STACK_DEPTH; s++) begin
                    rpc_q[w][s] <= {PC_BITS{1'b0}};
                    ppc_q[w][s] <= {PC_BITS{1'b0}};
                    pm_q[w][s]  <= {TPW{1'b0}};
                    sm_q[w][s]  <= {TPW{1'b0}};
                end
            end
            ovf_q        <= {NUM_WARPS{1'b0}};
            resp_valid_q <= 1'b0;
            resp_warp_q  <= {WARP_BITS{1'b0}};
            resp_mask_q  <= {TPW{1'b0}};
            resp_pc_q    <= {PC_BITS{1'b0}};
            resp_div_q   <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            depth_q      <= depth_d;
            rpc_q        <= rpc_d;
            ppc_q        <= ppc_d;
            pm_q         <= pm_d;
            sm_q         <= sm_d;
            ovf_q        <= ovf_d;
            resp_valid_q <= resp_valid_d;
            resp_warp_q  <= resp_warp_d;
            resp_mask_q  <= resp_mask_d;
            resp_pc_q    <= resp_pc_d;
            resp_div_q   <= resp_div_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready       = req_ready_s;
    assign resp_valid      = resp_valid_q;
    assign resp_warp       = resp_warp_q;
    assign resp_mask       = resp_mask_q;
    assign resp_pc         = resp_pc_q;
    assign resp_diverged   = resp_div_q;
    assign resp_error      = resp_err_q;
    assign overflow_sticky = ovf_q;

endmodule

// File: tb/tb_simt_reconv_stack.sv
// tb_simt_reconv_stack: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the per-warp reconvergence stacks.
module tb_simt_reconv_stack;

    localparam int NW  = 4;
    localparam int TPW = 8;
    localparam int SD  = 2;
    localparam int PCB = 8;
    localparam int WB  = 2;

    logic            clk;
    logic            reset;
    logic            init_valid;
    logic [WB-1:0]   init_warp;
    logic [TPW-1:0]  init_mask;
    logic            req_valid;
    logic            req_ready;
    logic [WB-1:0]   req_warp;
    logic            req_op;
    logic [TPW-1:0]  branch_taken;
    logic [PCB-1:0]  branch_target;
    logic [PCB-1:0]  fallthrough_pc;
    logic [PCB-1:0]  reconverge_pc;
    logic [PCB-1:0]  current_pc;
    logic            resp_valid;
    logic            resp_ready;
    logic [WB-1:0]   resp_warp;
    logic [TPW-1:0]  resp_mask;
    logic [PCB-1:0]  resp_pc;
    logic            resp_diverged;
    logic            resp_error;
    logic [NW-1:0]   overflow_sticky;

    simt_reconv_stack #(
        .NUM_WARPS(NW), .THREADS_PER_WARP(TPW), .STACK_DEPTH(SD), .PC_BITS(PCB)
    ) dut (
        .clk(clk), .reset(reset),
        .init_valid(init_valid), .init_warp(init_warp), .init_mask(init_mask),
        .req_valid(req_valid), .req_ready(req_ready), .req_warp(req_warp),
        .req_op(req_op), .branch_taken(branch_taken), .branch_target(branch_target),
        .fallthrough_pc(fallthrough_pc), .reconverge_pc(reconverge_pc),
        .current_pc(current_pc), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_warp(resp_warp), .resp_mask(resp_mask), .resp_pc(resp_pc),
        .resp_diverged(resp_diverged), .resp_error(resp_error),
        .overflow_sticky(overflow_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PCB-1:0] rpc;
        logic [PCB-1:0] ppc;
        logic [TPW-1:0] pm;
        logic [TPW-1:0] sm;
    } ent_t;

    ent_t           stk [NW][$];
    logic [TPW-1:0] m_mask [NW];
    logic [NW-1:0]  m_ovf;
    int             total = 0;
    int             bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_mask[w] = 8'hFF;
            stk[w].delete();
        end
        m_ovf = '0;
    endtask

    // Reference: apply one request to the model, return expected response
    task automatic model_req(input int w, input bit op, input logic [7:0] tk, tgt, ft, rc, cur,
                             output logic [7:0] e_mask, e_pc, output bit e_div, e_err);
        logic [7:0] a, t, n;
        ent_t e;
        a = m_mask[w]; t = a & tk; n = a & ~tk;
        e_mask = a; e_pc = cur; e_err = 1'b0;
        if (op) begin
            if (t == a) e_pc = tgt;
            else if (t == 8'h00) e_pc = ft;
            else if (stk[w].size() < SD) begin
                e.rpc = rc; e.ppc = ft; e.pm = n; e.sm = a;
                stk[w].push_back(e);
                m_mask[w] = t; e_mask = t; e_pc = tgt;
            end else begin
                e_err = 1'b1; m_ovf[w] = 1'b1;
            end
        end else if (stk[w].size() > 0 && stk[w][stk[w].size()-1].rpc == cur) begin
            e = stk[w].pop_back();
            if (e.pm != 8'h00) begin
                m_mask[w] = e.pm; e_mask = e.pm; e_pc = e.ppc;
                e.pm = 8'h00;
                stk[w].push_back(e);
            end else begin
                m_mask[w] = e.sm; e_mask = e.sm;
            end
        end
        e_div = (stk[w].size() > 0);
    endtask

    task automatic drive_req(input int w, input bit op, input logic [7:0] tk, tgt, ft, rc, cur);
        req_valid = 1'b1; req_warp = WB'(w); req_op = op; branch_taken = tk;
        branch_target = tgt; fallthrough_pc = ft; reconverge_pc = rc; current_pc = cur;
    endtask

    task automatic send(input int w, input bit op, input logic [7:0] tk, tgt, ft, rc, cur);
        logic [7:0] em, ep;
        bit ed, ee;
        int n;
        drive_req(w, op, tk, tgt, ft, rc, cur);
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            check_val("req_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        model_req(w, op, tk, tgt, ft, rc, cur, em, ep, ed, ee);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("resp_valid", 32'(resp_valid), 32'd1);
        check_val("resp_warp", 32'(resp_warp), 32'(w));
        check_val("resp_mask", 32'(resp_mask), 32'(em));
        check_val("resp_pc", 32'(resp_pc), 32'(ep));
        check_val("resp_div", 32'(resp_diverged), 32'(ed));
        check_val("resp_err", 32'(resp_error), 32'(ee));
        check_val("sticky", 32'(overflow_sticky), 32'(m_ovf));
    endtask

    task automatic do_init(input int w, input logic [7:0] m);
        init_valid = 1'b1; init_warp = WB'(w); init_mask = m;
        @(posedge clk); #1;
        init_valid = 1'b0;
        m_mask[w] = m; stk[w].delete(); m_ovf[w] = 1'b0;
        check_val("init_sticky", 32'(overflow_sticky), 32'(m_ovf));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int w, r;
        bit op;
        logic [7:0] tk, cur;
        reset = 1'b0; init_valid = 1'b0; init_warp = '0; init_mask = '0;
        req_valid = 1'b0; req_warp = '0; req_op = 1'b0; branch_taken = '0;
        branch_target = '0; fallthrough_pc = '0; reconverge_pc = '0; current_pc = '0;
        resp_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(resp_valid), 32'd0);
        check_val("rst_mask", 32'(resp_mask), 32'd0);
        check_val("rst_pc", 32'(resp_pc), 32'd0);
        check_val("rst_warp", 32'(resp_warp), 32'd0);
        check_val("rst_err", 32'(resp_error), 32'd0);
        check_val("rst_div", 32'(resp_diverged), 32'd0);
        check_val("rst_sticky", 32'(overflow_sticky), 32'd0);
        reset = 1'b1;

        // Reset mid-operation drops a held response at once
        resp_ready = 1'b0;
        send(0, 1'b1, 8'h0F, 8'h20, 8'h21, 8'h22, 8'h00);
        #2 reset = 1'b0;
        #1;
        check_val("rst_async_valid", 32'(resp_valid), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        send(0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10);
        check_val("sync0_mask", 32'(resp_mask), 32'h FF);

        // Divergence with nesting on warp 1
        send(1, 1'b1, 8'h0F, 8'h20, 8'h11, 8'h30, 8'h00);
        check_val("div_mask", 32'(resp_mask), 32'h0F);
        check_val("div_pc", 32'(resp_pc), 32'h20);
        send(1, 1'b1, 8'h03, 8'h40, 8'h41, 8'h28, 8'h00);
        check_val("nest_mask", 32'(resp_mask), 32'h03);
        send(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h28);
        check_val("nest_else", 32'(resp_mask), 32'h0C);
        send(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h28);
        check_val("nest_pop", 32'(resp_mask), 32'h0F);
        send(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h30);
        check_val("outer_else_mask", 32'(resp_mask), 32'hF0);
        check_val("outer_else_pc", 32'(resp_pc), 32'h11);
        send(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h30);
        check_val("outer_pop", 32'(resp_mask), 32'hFF);
        check_val("outer_div", 32'(resp_diverged), 32'd0);

        // Overflow on warp 2, cleared by init
        send(2, 1'b1, 8'h0F, 8'h50, 8'h51, 8'h52, 8'h00);
        send(2, 1'b1, 8'h03, 8'h53, 8'h54, 8'h55, 8'h00);
        send(2, 1'b1, 8'h01, 8'h56, 8'h57, 8'h58, 8'h5A);
        check_val("ovf_err", 32'(resp_error), 32'd1);
        check_val("ovf_mask", 32'(resp_mask), 32'h03);
        check_val("ovf_sticky", 32'(overflow_sticky[2]), 32'd1);
        do_init(2, 8'hFF);

        // Backpressure with interleaved warps 0 and 3
        resp_ready = 1'b0;
        send(0, 1'b1, 8'h55, 8'h50, 8'h51, 8'h60, 8'h00);
        drive_req(3, 1'b1, 8'hF0, 8'h70, 8'h71, 8'h80, 8'h00);
        #1;
        check_val("bp_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("bp_mask", 32'(resp_mask), 32'(m_mask[0]));
            check_val("bp_pc", 32'(resp_pc), 32'h50);
            check_val("bp_warp", 32'(resp_warp), 32'd0);
        end
        resp_ready = 1'b1;
        send(3, 1'b1, 8'hF0, 8'h70, 8'h71, 8'h80, 8'h00);
        send(0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60);
        check_val("il_w0", 32'(resp_mask), 32'hAA);
        send(3, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
        check_val("il_w3", 32'(resp_mask), 32'h0F);

        // Init collides with a request to the same warp
        init_valid = 1'b1; init_warp = 2'd1; init_mask = 8'h3C;
        drive_req(1, 1'b1, 8'h0C, 8'h90, 8'h91, 8'h92, 8'h00);
        #1;
        check_val("col_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        init_valid = 1'b0;
        m_mask[1] = 8'h3C; stk[1].delete(); m_ovf[1] = 1'b0;
        send(1, 1'b1, 8'h0C, 8'h90, 8'h91, 8'h92, 8'h00);
        check_val("col_mask", 32'(resp_mask), 32'h0C);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            w = $urandom_range(0, NW-1);
            if (r == 0) begin
                do_init(w, 8'($urandom));
            end else begin
                op = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0: tk = 8'h00;
                    1: tk = 8'hFF;
                    default: tk = 8'($urandom);
                endcase
                if (stk[w].size() > 0 && $urandom_range(0, 3) != 0)
                    cur = stk[w][stk[w].size()-1].rpc;
                else
                    cur = 8'($urandom);
                send(w, op, tk, 8'($urandom), 8'($urandom), 8'($urandom), cur);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
